// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_seq_pkg;

    localparam int unsigned D_DEF  = 12;
    localparam int unsigned OW_DEF = 8;
    localparam int unsigned SD_DEF = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } state_e;

    // Listed from highest to lowest priority. ReqCondBr is reported even when
    // the flag is clear; the sequencer qualifies it with the flag.
    typedef enum logic [2:0] {
        ReqNone,
        ReqStall,
        ReqHalt,
        ReqRet,
        ReqCall,
        ReqJump,
        ReqCondBr
    } req_e;

    function automatic req_e decode_req(input logic stall, input logic halt, input logic ret,
                                        input logic call, input logic jump, input logic cond_br);
        if (stall)   return ReqStall;
        if (halt)    return ReqHalt;
        if (ret)     return ReqRet;
        if (call)    return ReqCall;
        if (jump)    return ReqJump;
        if (cond_br) return ReqCondBr;
        return ReqNone;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder <-> sequencer signal bundle. The master is the decoder/PC side.
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int unsigned D  = D_DEF,
    parameter int unsigned OW = OW_DEF,
    parameter int unsigned SD = SD_DEF
);
    logic [D-1:0]             prg_ctr;
    logic                     start;
    logic                     stall;
    logic                     halt;
    logic                     jump;
    logic                     cond_br;
    logic                     flag;
    logic                     call;
    logic                     ret;
    logic [OW-1:0]            offset;
    logic [D-1:0]             abs_target;
    logic                     branch_abs;
    logic [D-1:0]             target;
    logic                     done;
    logic                     err;
    logic [$clog2(SD+1)-1:0]  depth;

    modport master (
        output prg_ctr, start, stall, halt, jump, cond_br, flag, call, ret, offset, abs_target,
        input  branch_abs, target, done, err, depth
    );

    modport slave (
        input  prg_ctr, start, stall, halt, jump, cond_br, flag, call, ret, offset, abs_target,
        output branch_abs, target, done, err, depth
    );

endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO addressed by its occupancy count.
module ret_stack #(
    parameter int unsigned D  = 12,
    parameter int unsigned SD = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clear,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [D-1:0]            i_push_data,
    output logic [D-1:0]            o_top,
    output logic [$clog2(SD+1)-1:0] o_depth,
    output logic                    o_full,
    output logic                    o_empty
);
    localparam int unsigned DW = $clog2(SD + 1);
    localparam int unsigned AW = (SD > 1) ? $clog2(SD) : 1;

    logic [D-1:0]  r_mem [SD];
    logic [DW-1:0] r_depth;
    logic [DW-1:0] w_top_idx;

    assign w_top_idx = r_depth - DW'(1);
    assign o_full    = (r_depth == DW'(SD));
    assign o_empty   = (r_depth == '0);
    assign o_depth   = r_depth;
    assign o_top     = o_empty ? '0 : r_mem[w_top_idx[AW-1:0]];

    // Occupancy: clear wins, then push, then pop; overflow/underflow requests are dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_depth <= '0;
        end else if (i_clear) begin
            r_depth <= '0;
        end else if (i_push && !o_full) begin
            r_depth <= r_depth + DW'(1);
        end else if (i_pop && !o_empty) begin
            r_depth <= r_depth - DW'(1);
        end
    end

    // Entry storage; contents beyond the occupancy are don't-care, so no reset.
    always_ff @(posedge i_clk) begin
        if (i_push && !o_full && !i_clear) begin
            r_mem[r_depth[AW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC control sequencer: start/halt FSM, request priority, relative adder, call/return.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned D  = D_DEF,
    parameter int unsigned OW = OW_DEF,
    parameter int unsigned SD = SD_DEF
) (
    input logic           i_clk,
    input logic           i_rst_n,
    pc_sequencer_if.slave bus
);
    state_e                  r_state;
    state_e                  w_state_nxt;
    logic                    r_err;
    logic                    w_err_set;
    logic                    w_err_clr;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_clear;
    logic                    w_branch_abs;
    logic [D-1:0]            w_target;
    logic [D-1:0]            w_top;
    logic [D-1:0]            w_off_ext;
    logic [D-1:0]            w_rel_tgt;
    logic [D-1:0]            w_ret_addr;
    logic                    w_full;
    logic                    w_empty;
    logic [$clog2(SD+1)-1:0] w_depth;
    req_e                    w_req;

    assign w_off_ext  = {{(D - OW){bus.offset[OW-1]}}, bus.offset};
    assign w_rel_tgt  = bus.prg_ctr + w_off_ext;
    assign w_ret_addr = bus.prg_ctr + D'(1);
    assign w_req      = decode_req(bus.stall, bus.halt, bus.ret, bus.call, bus.jump,
                                   bus.cond_br);

    ret_stack #(
        .D  (D),
        .SD (SD)
    ) u_ret_stack (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_clear),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_ret_addr),
        .o_top       (w_top),
        .o_depth     (w_depth),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // State and sticky error registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_err_clr) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next state, stack control and PC load; default is hold (load current PC).
    always_comb begin
        w_state_nxt  = r_state;
        w_branch_abs = 1'b1;
        w_target     = bus.prg_ctr;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_clear      = 1'b0;
        w_err_set    = 1'b0;
        w_err_clr    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_target    = '0;
                    w_state_nxt = StRun;
                end
            end
            StHalted: begin
                if (bus.start) begin
                    w_target    = '0;
                    w_clear     = 1'b1;
                    w_err_clr   = 1'b1;
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                unique case (w_req)
                    ReqStall: ;
                    ReqHalt:  w_state_nxt = StHalted;
                    ReqRet: begin
                        if (!w_empty) begin
                            w_pop    = 1'b1;
                            w_target = w_top;
                        end else begin
                            w_err_set    = 1'b1;
                            w_branch_abs = 1'b0;
                            w_target     = '0;
                        end
                    end
                    ReqCall: begin
                        if (!w_full) begin
                            w_push   = 1'b1;
                            w_target = bus.abs_target;
                        end else begin
                            w_err_set    = 1'b1;
                            w_branch_abs = 1'b0;
                            w_target     = '0;
                        end
                    end
                    ReqJump:  w_target = bus.abs_target;
                    ReqCondBr: begin
                        if (bus.flag) begin
                            w_target = w_rel_tgt;
                        end else begin
                            w_branch_abs = 1'b0;
                            w_target     = '0;
                        end
                    end
                    default: begin
                        w_branch_abs = 1'b0;
                        w_target     = '0;
                    end
                endcase
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign bus.branch_abs = w_branch_abs;
    assign bus.target     = w_target;
    assign bus.done       = (r_state == StHalted);
    assign bus.err        = r_err;
    assign bus.depth      = w_depth;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, self-checking bench for pc_sequencer with a PC-load scoreboard.
module tb_pc_sequencer;

    typedef struct {
        string       tag;
        logic        ba;
        logic [11:0] tgt;
    } exp_t;

    logic   clk;
    logic   rst_n;
    int     n_pass;
    int     n_total;
    exp_t   sb_q[$];

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.stall      = 1'b0;
        bus.halt       = 1'b0;
        bus.jump       = 1'b0;
        bus.cond_br    = 1'b0;
        bus.flag       = 1'b0;
        bus.call       = 1'b0;
        bus.ret        = 1'b0;
        bus.offset     = '0;
        bus.abs_target = '0;
    endtask

    // Record the expected PC load for the request just driven.
    task automatic exp_load(input string tag, input logic ba, input logic [11:0] tgt);
        exp_t e;
        e.tag = tag;
        e.ba  = ba;
        e.tgt = tgt;
        sb_q.push_back(e);
    endtask

    // Compare combinational outputs against the oldest expectation, then clock.
    task automatic settle_and_clock();
        exp_t e;
        #1;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, ".ba"}, {31'd0, bus.branch_abs}, {31'd0, e.ba});
            chk({e.tag, ".tgt"}, {20'd0, bus.target}, {20'd0, e.tgt});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_call(input string tag, input logic [11:0] pc, input logic [11:0] tgt,
                           input logic ok);
        @(negedge clk);
        idle_inputs();
        bus.prg_ctr    = pc;
        bus.call       = 1'b1;
        bus.abs_target = tgt;
        exp_load(tag, ok, ok ? tgt : 12'h000);
        settle_and_clock();
    endtask

    task automatic do_ret(input string tag, input logic [11:0] pc, input logic ok,
                          input logic [11:0] tgt);
        @(negedge clk);
        idle_inputs();
        bus.prg_ctr = pc;
        bus.ret     = 1'b1;
        exp_load(tag, ok, tgt);
        settle_and_clock();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        idle_inputs();
        bus.prg_ctr = 12'h123;
        rst_n       = 1'b0;

        // Reset state
        #1;
        chk("rst_depth", 32'(bus.depth), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        exp_load("rst_hold", 1'b1, 12'h123);
        settle_and_clock();

        // IDLE holds
        @(negedge clk);
        rst_n       = 1'b1;
        bus.prg_ctr = 12'h045;
        exp_load("idle_hold", 1'b1, 12'h045);
        settle_and_clock();

        // Start from IDLE
        @(negedge clk);
        bus.start = 1'b1;
        exp_load("idle_start", 1'b1, 12'h000);
        settle_and_clock();

        // RUN with no request: sequential
        @(negedge clk);
        idle_inputs();
        bus.prg_ctr = 12'h000;
        exp_load("run_seq", 1'b0, 12'h000);
        settle_and_clock();

        // Start in RUN is ignored
        @(negedge clk);
        bus.prg_ctr = 12'h010;
        bus.start   = 1'b1;
        exp_load("run_start_ign", 1'b0, 12'h000);
        settle_and_clock();

        // Relative branches with wrap
        @(negedge clk);
        idle_inputs();
        bus.prg_ctr = 12'h005;
        bus.cond_br = 1'b1;
        bus.flag    = 1'b1;
        bus.offset  = 8'hF8;
        exp_load("br_neg_wrap", 1'b1, 12'hFFD);
        settle_and_clock();

        @(negedge clk);
        bus.prg_ctr = 12'hFFE;
        bus.offset  = 8'h03;
        exp_load("br_pos_wrap", 1'b1, 12'h001);
        settle_and_clock();

        @(negedge clk);
        bus.prg_ctr = 12'h020;
        bus.flag    = 1'b0;
        exp_load("br_not_taken", 1'b0, 12'h000);
        settle_and_clock();

        // Absolute jump
        @(negedge clk);
        idle_inputs();
        bus.prg_ctr    = 12'h030;
        bus.jump       = 1'b1;
        bus.abs_target = 12'h456;
        exp_load("jump", 1'b1, 12'h456);
        settle_and_clock();

        // Nested calls fill the stack
        do_call("call0", 12'h010, 12'h0A0, 1'b1);
        chk("depth_c0", 32'(bus.depth), 32'd1);
        do_call("call1", 12'h100, 12'h0B0, 1'b1);
        do_call("call2", 12'h200, 12'h0C0, 1'b1);
        do_call("call3", 12'h300, 12'h0D0, 1'b1);
        chk("depth_full", 32'(bus.depth), 32'd4);
        chk("err_before_ovf", 32'(bus.err), 32'd0);
        do_call("call_ovf", 12'h3FF, 12'h0E0, 1'b0);
        chk("err_ovf", 32'(bus.err), 32'd1);
        chk("depth_ovf", 32'(bus.depth), 32'd4);

        // Returns unwind in LIFO order
        do_ret("ret3", 12'h0D5, 1'b1, 12'h301);
        chk("depth_r3", 32'(bus.depth), 32'd3);
        do_ret("ret2", 12'h301, 1'b1, 12'h201);
        do_ret("ret1", 12'h201, 1'b1, 12'h101);
        do_ret("ret0", 12'h101, 1'b1, 12'h011);
        chk("depth_empty", 32'(bus.depth), 32'd0);
        do_ret("ret_unf", 12'h011, 1'b0, 12'h000);
        chk("err_unf", 32'(bus.err), 32'd1);
        chk("depth_unf", 32'(bus.depth), 32'd0);

        // Call immediately followed by Ret
        do_call("call_bt", 12'h050, 12'h600, 1'b1);
        do_ret("ret_bt", 12'h600, 1'b1, 12'h051);
        chk("err_sticky", 32'(bus.err), 32'd1);

        // Two entries on the stack before halting
        do_call("call_h0", 12'h070, 12'h700, 1'b1);
        do_call("call_h1", 12'h700, 12'h800, 1'b1);
        chk("depth_pre_halt", 32'(bus.depth), 32'd2);

        // Priority: Stall beats Halt and Jump
        @(negedge clk);
        idle_inputs();
        bus.prg_ctr    = 12'h222;
        bus.stall      = 1'b1;
        bus.halt       = 1'b1;
        bus.jump       = 1'b1;
        bus.abs_target = 12'h777;
        exp_load("stall_prio", 1'b1, 12'h222);
        settle_and_clock();
        chk("stall_done", 32'(bus.done), 32'd0);
        chk("stall_depth", 32'(bus.depth), 32'd2);

        // Halt beats Jump
        @(negedge clk);
        bus.stall = 1'b0;
        exp_load("halt_prio", 1'b1, 12'h222);
        settle_and_clock();
        chk("halt_done", 32'(bus.done), 32'd1);

        // HALTED holds
        @(negedge clk);
        idle_inputs();
        bus.prg_ctr = 12'h333;
        exp_load("halted_hold", 1'b1, 12'h333);
        settle_and_clock();
        chk("halted_err", 32'(bus.err), 32'd1);

        // Restart from HALTED clears stack and error
        @(negedge clk);
        bus.start = 1'b1;
        exp_load("restart", 1'b1, 12'h000);
        settle_and_clock();
        chk("restart_depth", 32'(bus.depth), 32'd0);
        chk("restart_err", 32'(bus.err), 32'd0);
        chk("restart_done", 32'(bus.done), 32'd0);

        // Build Depth=3 with Err=1, then reset asynchronously mid-cycle
        do_call("call_r0", 12'h400, 12'h410, 1'b1);
        do_call("call_r1", 12'h410, 12'h420, 1'b1);
        do_call("call_r2", 12'h420, 12'h430, 1'b1);
        do_call("call_r3", 12'h430, 12'h440, 1'b1);
        do_call("call_r_ovf", 12'h440, 12'h450, 1'b0);
        do_ret("ret_r3", 12'h440, 1'b1, 12'h431);
        chk("pre_rst_depth", 32'(bus.depth), 32'd3);
        chk("pre_rst_err", 32'(bus.err), 32'd1);

        @(negedge clk);
        idle_inputs();
        bus.prg_ctr = 12'h444;
        #1;
        chk("pre_rst_seq", 32'(bus.branch_abs), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_depth", 32'(bus.depth), 32'd0);
        chk("arst_err", 32'(bus.err), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        exp_load("arst_hold", 1'b1, 12'h444);
        settle_and_clock();

        // Back in IDLE after release: Start works again
        @(negedge clk);
        rst_n       = 1'b1;
        bus.prg_ctr = 12'h555;
        exp_load("post_rst_idle", 1'b1, 12'h555);
        settle_and_clock();
        @(negedge clk);
        bus.start = 1'b1;
        exp_load("post_rst_start", 1'b1, 12'h000);
        settle_and_clock();

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
